keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 active-low key matrix and debounces it. Produces the 4-bit key code that feeds
//  the key input of the tone-generator stage (music). The code is held steady while a key is
//  down and returns to 0 on release.
//  Code = matrix position p+1 (p = row*4 + col) for p = 0..12. Positions 13..15 are unmapped.
// PARAMETERS
//  SCAN_DIV        25000  sysclk cycles per column step; must be >= 4 (25 MHz -> 1 ms/column)
//  DEBOUNCE_SCANS  8      consecutive identical full-matrix frames before key updates; range 1..15
//  REPEAT_FRAMES   32     frames between auto-repeat key_event pulses (KEYPAD_REPEAT_EN only)
// PORTS
//  sysclk     in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  row_in     in   4  matrix rows, active-low, externally pulled up, asynchronous to sysclk
//  col_out    out  4  column drive, active-low, exactly one bit low at any time
//  key        out  4  debounced key code: 0 = none, 1..13 = pressed key
//  key_valid  out  1  1 when key != 0
//  key_event  out  1  one-cycle pulse each time key changes value
// BEHAVIOUR
//  Reset values:
//   - col_out = 4'b1110; key = 0; key_valid = 0; key_event = 0.
//   - Divider, column index, frame accumulator, candidate and stable count all cleared.
//   - Reset asserted mid-scan or mid-debounce abandons that progress; the next frame starts at column 0.
//  Input sync: row_in passes through a 2-FF synchroniser before any use (2-cycle latency).
//  Column scan:
//   - div_cnt counts 0..SCAN_DIV-1; col_idx advances 0->1->2->3->0 when div_cnt == SCAN_DIV-1.
//   - col_out = ~(4'b0001 << col_idx).
//   - Synchronised rows are sampled only when div_cnt == SCAN_DIV-1 (settle + sync margin).
//   - Each sample is stored inverted into the 16-bit frame map at bits {row, col_idx}.
//  Frame end (col_idx == 3 and div_cnt == SCAN_DIV-1); this cycle's samples are included:
//   - cand = lowest mapped position p (0..12) that is pressed in the frame, as code p+1.
//     If none is pressed, cand = 0.
//   - Pressed unmapped positions 13..15 are ignored. With several keys pressed, the lowest p wins.
//   - If cand == prev_cand: stable_cnt = min(stable_cnt + 1, DEBOUNCE_SCANS). Otherwise stable_cnt = 1.
//     Then prev_cand <= cand.
//   - If stable_cnt (new value) == DEBOUNCE_SCANS and cand != key:
//     key <= cand and key_event = 1 for the following cycle.
//   - Frame map clears for the next frame.
//  Timing:
//   - One frame = 4*SCAN_DIV cycles.
//   - A clean press or release updates key at the end of the DEBOUNCE_SCANS-th frame that fully
//     contains it. Worst case: (DEBOUNCE_SCANS + 1) frames + 3 cycles.
//  Boundaries:
//   - A change in the middle of a frame gives a mixed candidate; stable counting handles it.
//   - Press-to-press transitions (key A -> key B with no release between) update key directly,
//     with a single key_event.
//   - key_valid is registered together with key, so the two never disagree.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined:
//   - While key != 0 and unchanged, a repeat counter counts frame ends.
//   - Each time it reaches REPEAT_FRAMES it pulses key_event for 1 cycle and restarts.
//   - The counter clears on any key change and on reset.
//  KEYPAD_REPEAT_EN undefined:
//   - key_event pulses only on key changes; no repeat counter is built.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_FRAMES=4; frame = 16 cycles)
//  1. Assert reset for 3 cycles, row_in = 4'hF
//     -> col_out = 4'b1110, key = 0, key_valid = 0, key_event = 0; col_out then rotates every 4 cycles.
//  2. Model the matrix; hold row1/col2 pressed (p = 6)
//     -> key = 7, key_valid = 1 within 67 cycles; exactly one key_event pulse.
//  3. Press row1/col2 for one frame, release one frame, press one frame
//     -> key stays 0; no key_event.
//  4. Hold row0/col1 (p = 1) and row2/col0 (p = 8) together -> key = 2.
//     Additionally hold row3/col3 (p = 15) -> key = 2 unchanged.
//     Hold only p = 15 -> key = 0.
//  5. From key = 7, release all; also assert reset 10 cycles into the release debounce.
//     Release without the reset -> key = 0 after 3 stable frames, one key_event.
//     Release with the reset -> outputs at reset values, debounce restarts.
//  6. With KEYPAD_REPEAT_EN, hold p = 6 for 20 frames
//     -> key_event at the press plus every 4 frames (4 repeats); without the macro -> a single pulse.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
//   Groups the key-matrix pins and the debounced key outputs of keypad_scanner.
//   master : the scanner (samples rows, drives columns and key outputs)
//   slave  : the matrix / consumer side (drives rows, observes everything else)
// Signals
//   row_in    [3:0]  matrix rows, active-low, asynchronous to sysclk
//   col_out   [3:0]  column drive, active-low, one-hot-low
//   key       [3:0]  debounced key code, 0 = none, 1..13 = pressed key
//   key_valid        1 when key != 0
//   key_event        one-cycle pulse on every key change (and auto-repeat)
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key;
   logic       key_valid;
   logic       key_event;

   modport master (
      input  row_in,
      output col_out,
      output key,
      output key_valid,
      output key_event
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key,
      input  key_valid,
      input  key_event
   );
endinterface

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low key matrix one column at a time, accumulates a
//   full-matrix frame, and debounces the lowest pressed mapped key (positions
//   0..12, reported as code p+1). The key code feeds the tone generator; it
//   stays steady while a key is held and returns to 0 on release.
// Ports
//   sysclk      system clock
//   reset       synchronous, active-high reset
//   kp.row_in   matrix rows, active-low, asynchronous (2-FF synchronised here)
//   kp.col_out  column drive, active-low, exactly one bit low
//   kp.key      debounced key code
//   kp.key_valid  key != 0, registered alongside key
//   kp.key_event  one-cycle pulse whenever key changes
// Parameters
//   SCAN_DIV        sysclk cycles per column step (>= 4)
//   DEBOUNCE_SCANS  identical consecutive frames required before key updates (1..15)
//   REPEAT_FRAMES   frames between auto-repeat key_event pulses
// Configuration
//   KEYPAD_REPEAT_EN  when defined, a held key re-pulses key_event every
//                     REPEAT_FRAMES frames; when undefined no repeat logic exists.
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 8,
   parameter int REPEAT_FRAMES  = 32
) (
   input  logic             sysclk,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam int               DIV_W       = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_N       = 4'(DEBOUNCE_SCANS);
   localparam logic [15:0]      MAPPED_MASK = 16'h1FFF;

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_scanner: SCAN_DIV must be >= 4");
   end
   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
      $error("keypad_scanner: DEBOUNCE_SCANS must be in 1..15");
   end
   if (REPEAT_FRAMES < 1) begin : g_bad_repeat
      $error("keypad_scanner: REPEAT_FRAMES must be >= 1");
   end

   // Saturating increment of the stable-frame counter.
   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      return (cnt >= DEB_N) ? DEB_N : 4'(cnt + 4'd1);
   endfunction

   // Lowest pressed mapped position as code p+1; unmapped 13..15 are masked off.
   function automatic logic [3:0] lowest_code(input logic [15:0] map);
      logic [15:0] m;
      logic [3:0]  code;
      m    = map & MAPPED_MASK;
      code = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) code = 4'(i + 1);
      end
      return code;
   endfunction

   logic [3:0]       row_meta_q, row_meta_d;
   logic [3:0]       row_sync_q, row_sync_d;
   logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
   logic [1:0]       col_idx_q,  col_idx_d;
   logic [3:0]       col_out_q,  col_out_d;
   logic [15:0]      frame_map_q, frame_map_d;
   logic [3:0]       prev_cand_q, prev_cand_d;
   logic [3:0]       stable_cnt_q, stable_cnt_d;
   logic [3:0]       key_q,       key_d;
   logic             key_valid_q, key_valid_d;
   logic             key_event_q, key_event_d;

   // Frame map including the current column's sample, and the frame-end decision.
   logic [15:0]      map_now;
   logic [3:0]       cand;
   logic [3:0]       stable_new;

`ifdef KEYPAD_REPEAT_EN
   localparam int             RPT_W    = $clog2(REPEAT_FRAMES + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

   always_comb begin
      row_meta_d   = kp.row_in;
      row_sync_d   = row_meta_q;
      div_cnt_d    = DIV_W'(div_cnt_q + 1'b1);
      col_idx_d    = col_idx_q;
      frame_map_d  = frame_map_q;
      prev_cand_d  = prev_cand_q;
      stable_cnt_d = stable_cnt_q;
      key_d        = key_q;
      key_valid_d  = key_valid_q;
      key_event_d  = 1'b0;
      map_now      = frame_map_q;
      cand         = 4'd0;
      stable_new   = stable_cnt_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d    = rpt_cnt_q;
`endif

      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
         col_idx_d = 2'(col_idx_q + 2'd1);

         // Rows are sampled at the end of the column slot so the drive has
         // settled and the synchroniser has caught up. Stored active-high.
         for (int r = 0; r < 4; r++) begin
            map_now[{2'(r), col_idx_q}] = ~row_sync_q[r];
         end
         frame_map_d = map_now;

         if (col_idx_q == 2'd3) begin
            cand         = lowest_code(map_now);
            stable_new   = (cand == prev_cand_q) ? sat_inc(stable_cnt_q) : 4'd1;
            stable_cnt_d = stable_new;
            prev_cand_d  = cand;
            frame_map_d  = '0;

            if (stable_new == DEB_N && cand != key_q) begin
               key_d       = cand;
               key_valid_d = (cand != 4'd0);
               key_event_d = 1'b1;
            end

`ifdef KEYPAD_REPEAT_EN
            // Repeat counting only while a key is held and not changing now.
            if (key_d != key_q || key_q == 4'd0) begin
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == RPT_LAST) begin
               rpt_cnt_d   = '0;
               key_event_d = 1'b1;
            end else begin
               rpt_cnt_d = RPT_W'(rpt_cnt_q + 1'b1);
            end
`endif
         end
      end

      col_out_d = ~(4'b0001 << col_idx_d);
   end

   always_ff @(posedge sysclk) begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      if (reset) begin
         div_cnt_q    <= '0;
         col_idx_q    <= 2'd0;
         col_out_q    <= 4'b1110;
         frame_map_q  <= '0;
         prev_cand_q  <= 4'd0;
         stable_cnt_q <= 4'd0;
         key_q        <= 4'd0;
         key_valid_q  <= 1'b0;
         key_event_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt_q    <= '0;
`endif
      end else begin
         div_cnt_q    <= div_cnt_d;
         col_idx_q    <= col_idx_d;
         col_out_q    <= col_out_d;
         frame_map_q  <= frame_map_d;
         prev_cand_q  <= prev_cand_d;
         stable_cnt_q <= stable_cnt_d;
         key_q        <= key_d;
         key_valid_q  <= key_valid_d;
         key_event_q  <= key_event_d;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt_q    <= rpt_cnt_d;
`endif
      end
   end

   assign kp.col_out   = col_out_q;
   assign kp.key       = key_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_event = key_event_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Drives a modelled 4x4 key matrix into keypad_scanner (SCAN_DIV=4,
//   DEBOUNCE_SCANS=3, REPEAT_FRAMES=4, so one frame = 16 cycles).
//   Stimulus pushes each expected new key code into a queue; a monitor pops
//   and compares on every key_event that changes key.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_SCANS = 3;
   localparam int REPEAT_FRAMES  = 4;
   localparam int FRAME          = 4 * SCAN_DIV;
   localparam int SETTLE_BUDGET  = (DEBOUNCE_SCANS + 1) * FRAME + 3;

   logic clk;
   logic reset;
   logic [15:0] pressed;
   logic [3:0]  rows;

   int checks;
   int failures;
   int rpt_seen;
   logic [3:0] exp_q[$];
   logic [3:0] key_prev_s;

   keypad_scanner_if kif();

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_FRAMES  (REPEAT_FRAMES)
   ) dut (
      .sysclk (clk),
      .reset  (reset),
      .kp     (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix model: a pressed switch pulls its row low while its column is driven low.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c] && !kif.col_out[c]) rows[r] = 1'b0;
         end
      end
   end
   assign kif.row_in = rows;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic expect_key(input logic [3:0] code);
      exp_q.push_back(code);
   endtask

   // Waits (bounded) for the monitor to consume all expected key changes.
   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s: timeout, %0d key change(s) still pending, key=%0d expected %0d",
                  name, exp_q.size(), kif.key, exp_q[0]);
         exp_q.delete();
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard.
   initial begin
      logic [3:0] e;
      key_prev_s = 4'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            key_prev_s = kif.key;
         end else begin
            if (kif.key_event) begin
               if (kif.key != key_prev_s) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL unexpected_change: key=%0d, expected no change from %0d",
                              kif.key, key_prev_s);
                  end else begin
                     e = exp_q.pop_front();
                     if (kif.key !== e || kif.key_valid !== (e != 4'd0)) begin
                        failures++;
                        $display("FAIL key_change: key=%0d valid=%0b, expected key=%0d valid=%0b",
                                 kif.key, kif.key_valid, e, (e != 4'd0));
                     end
                  end
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  rpt_seen++;
`else
                  checks++;
                  failures++;
                  $display("FAIL unexpected_repeat: key_event=1 with key unchanged at %0d, expected 0",
                           kif.key);
`endif
               end
            end else if (kif.key != key_prev_s) begin
               checks++;
               failures++;
               $display("FAIL silent_change: key=%0d without key_event, expected %0d",
                        kif.key, key_prev_s);
            end
            key_prev_s = kif.key;
         end
      end
   end

   // Global watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] col_exp;
      int         rpt0;
      checks   = 0;
      failures = 0;
      rpt_seen = 0;
      pressed  = 16'h0000;
      reset    = 1'b1;

      // 1. Reset values and column rotation.
      cycles(3);
      check("reset_col_out",   kif.col_out,   4'b1110);
      check("reset_key",       kif.key,       4'd0);
      check("reset_key_valid", kif.key_valid, 1'b0);
      check("reset_key_event", kif.key_event, 1'b0);
      reset = 1'b0;
      col_exp = 4'b1110;
      for (int k = 0; k < 4; k++) begin
         cycles(SCAN_DIV);
         col_exp = {col_exp[2:0], col_exp[3]};
         check("col_rotate", kif.col_out, col_exp);
      end

      // 3. One-frame press / release / press glitch never debounces.
      pressed = 16'h0001 << 6;
      cycles(FRAME);
      pressed = 16'h0000;
      cycles(FRAME);
      pressed = 16'h0001 << 6;
      cycles(FRAME);
      pressed = 16'h0000;
      cycles(6 * FRAME);
      check("glitch_key",       kif.key,       4'd0);
      check("glitch_key_valid", kif.key_valid, 1'b0);

      // 2. Hold row1/col2 (p=6) -> key 7.
      pressed = 16'h0001 << 6;
      expect_key(4'd7);
      wait_drain("press_p6", SETTLE_BUDGET);
      check("press_key",       kif.key,       4'd7);
      check("press_key_valid", kif.key_valid, 1'b1);
      cycles(3 * FRAME);
      check("hold_key", kif.key, 4'd7);

      // 5a. Release -> key 0 after debounce.
      pressed = 16'h0000;
      expect_key(4'd0);
      wait_drain("release", SETTLE_BUDGET);
      check("release_key",       kif.key,       4'd0);
      check("release_key_valid", kif.key_valid, 1'b0);

      // 4. Multiple keys: lowest mapped wins, unmapped ignored.
      pressed = (16'h0001 << 1) | (16'h0001 << 8);
      expect_key(4'd2);
      wait_drain("multi_p1_p8", SETTLE_BUDGET);
      check("multi_key", kif.key, 4'd2);
      pressed = pressed | (16'h0001 << 15);
      cycles(6 * FRAME);
      check("multi_plus_p15_key", kif.key, 4'd2);
      pressed = 16'h0001 << 15;
      expect_key(4'd0);
      wait_drain("only_p15", SETTLE_BUDGET);
      check("only_p15_key",   kif.key,       4'd0);
      check("only_p15_valid", kif.key_valid, 1'b0);

      // Press-to-press: p6 then p9 with no release between.
      pressed = 16'h0001 << 6;
      expect_key(4'd7);
      wait_drain("p2p_first", SETTLE_BUDGET);
      pressed = 16'h0001 << 9;
      expect_key(4'd10);
      wait_drain("p2p_second", SETTLE_BUDGET);
      check("p2p_key", kif.key, 4'd10);
      pressed = 16'h0000;
      expect_key(4'd0);
      wait_drain("p2p_release", SETTLE_BUDGET);

      // 5b. Reset 10 cycles into a release debounce.
      pressed = 16'h0001 << 6;
      expect_key(4'd7);
      wait_drain("pre_reset_press", SETTLE_BUDGET);
      pressed = 16'h0000;
      cycles(10);
      reset = 1'b1;
      cycles(1);
      check("midreset_col_out",   kif.col_out,   4'b1110);
      check("midreset_key",       kif.key,       4'd0);
      check("midreset_key_valid", kif.key_valid, 1'b0);
      check("midreset_key_event", kif.key_event, 1'b0);
      cycles(1);
      reset = 1'b0;
      cycles(SCAN_DIV);
      check("post_reset_col1", kif.col_out, 4'b1101);
      cycles(6 * FRAME);
      check("post_reset_key", kif.key, 4'd0);

      // 6. Long hold: auto-repeat pulses only with the repeat build.
      pressed = 16'h0001 << 6;
      expect_key(4'd7);
      wait_drain("repeat_press", SETTLE_BUDGET);
      rpt0 = rpt_seen;
      cycles(4 * REPEAT_FRAMES * FRAME + 8);
`ifdef KEYPAD_REPEAT_EN
      check("repeat_pulses", rpt_seen - rpt0, 4);
`else
      check("repeat_pulses", rpt_seen - rpt0, 0);
`endif
      check("repeat_hold_key", kif.key, 4'd7);
      pressed = 16'h0000;
      expect_key(4'd0);
      wait_drain("repeat_release", SETTLE_BUDGET);

      cycles(2 * FRAME);
      check("final_pending", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
